// File: rtl/price_threshold_detect.sv
// -----------------------------------------------------------------------------
// price_threshold_detect
//
// Purpose:
//   Classifies each 8-bit price sample against an upper and a lower band and
//   tracks a debounced three-state condition (BAND / HIGH / LOW). Leaving BAND
//   requires DEBOUNCE_CYCLES consecutive out-of-band samples on the same side.
//   Returning to BAND from HIGH or LOW is immediate on the first sample that
//   is not on the current side.
//
// Parameters:
//   UPPER_BAND      - upper threshold (price > UPPER_BAND is ABOVE)
//   LOWER_BAND      - lower threshold (price < LOWER_BAND is BELOW)
//   DEBOUNCE_CYCLES - consecutive ABOVE/BELOW samples needed to leave BAND (>= 1)
//
// Ports:
//   clk    in   1  clock, all state updates on the rising edge
//   reset  in   1  synchronous active-high reset
//   price  in   8  unsigned price sample, taken every rising edge
//   out    out  2  registered state code: 01 = BAND, 11 = HIGH, 10 = LOW
// -----------------------------------------------------------------------------
module price_threshold_detect #(
  parameter logic [7:0] UPPER_BAND      = 8'd105,
  parameter logic [7:0] LOWER_BAND      = 8'd95,
  parameter int         DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] price,
  output logic [1:0] out
);

  // State encodings double as the output code, so out comes straight off the
  // state register.
  localparam logic [1:0] ST_BAND = 2'b01;
  localparam logic [1:0] ST_HIGH = 2'b11;
  localparam logic [1:0] ST_LOW  = 2'b10;

  // Counters hold up to DEBOUNCE_CYCLES and saturate there.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  // Count already held when the sample being taken is the last one needed.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_up_cnt;
  logic [CNT_W-1:0] r_dn_cnt;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_up_nxt;
  logic [CNT_W-1:0] w_dn_nxt;
  logic [CNT_W-1:0] w_up_inc;
  logic [CNT_W-1:0] w_dn_inc;
  logic             w_above;
  logic             w_below;

  // Equal to either band counts as in-band, hence the strict comparisons.
  assign w_above = (price > UPPER_BAND);
  assign w_below = (price < LOWER_BAND);

  assign w_up_inc = (r_up_cnt == CNT_MAX) ? CNT_MAX : r_up_cnt + CNT_ONE;
  assign w_dn_inc = (r_dn_cnt == CNT_MAX) ? CNT_MAX : r_dn_cnt + CNT_ONE;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_up_nxt    = CNT_ZERO;
    w_dn_nxt    = CNT_ZERO;

    case (r_state)
      ST_BAND: begin
        if (w_above) begin
          // ">=" rather than "==" so a counter preloaded to 1 on the way out
          // of LOW still completes correctly when DEBOUNCE_CYCLES is 1.
          if (r_up_cnt >= CNT_LAST) begin
            w_state_nxt = ST_HIGH;
          end else begin
            w_up_nxt = w_up_inc;
          end
        end else if (w_below) begin
          if (r_dn_cnt >= CNT_LAST) begin
            w_state_nxt = ST_LOW;
          end else begin
            w_dn_nxt = w_dn_inc;
          end
        end
      end

      ST_HIGH: begin
        if (w_below) begin
          // Drop to BAND with this sample already counted as the first BELOW;
          // HIGH never goes straight to LOW.
          w_state_nxt = ST_BAND;
          w_dn_nxt    = CNT_ONE;
        end else if (!w_above) begin
          w_state_nxt = ST_BAND;
        end
      end

      ST_LOW: begin
        if (w_above) begin
          w_state_nxt = ST_BAND;
          w_up_nxt    = CNT_ONE;
        end else if (!w_below) begin
          w_state_nxt = ST_BAND;
        end
      end

      default: begin
        // Unreachable encoding (00): recover to BAND.
        w_state_nxt = ST_BAND;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state  <= ST_BAND;
      r_up_cnt <= CNT_ZERO;
      r_dn_cnt <= CNT_ZERO;
    end else begin
      r_state  <= w_state_nxt;
      r_up_cnt <= w_up_nxt;
      r_dn_cnt <= w_dn_nxt;
    end
  end

  assign out = r_state;

endmodule

// File: tb/tb_price_threshold_detect.sv
// -----------------------------------------------------------------------------
// tb_price_threshold_detect
//
// Directed self-checking bench for price_threshold_detect with default
// parameters (UPPER_BAND=105, LOWER_BAND=95, DEBOUNCE_CYCLES=3). Each step
// drives one price sample, clocks one rising edge and checks out 1 ns later
// against a hand-computed value.
// -----------------------------------------------------------------------------
module tb_price_threshold_detect;

  localparam logic [1:0] BAND = 2'b01;
  localparam logic [1:0] HIGH = 2'b11;
  localparam logic [1:0] LOW  = 2'b10;

  logic       clk;
  logic       reset;
  logic [7:0] price;
  logic [1:0] out;

  int checks;
  int errors;

  price_threshold_detect #(
    .UPPER_BAND      (8'd105),
    .LOWER_BAND      (8'd95),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .price (price),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] expected);
    checks++;
    assert (out === expected) else begin
      errors++;
      $display("FAIL %s: out=%b expected=%b", tag, out, expected);
      $error("%s: observed %b expected %b", tag, out, expected);
    end
  endtask

  // One sample: drive price, take one rising edge, check shortly after it.
  task automatic step(input logic [7:0] p, input logic [1:0] expected, input string tag);
    price = p;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  task automatic reset_step(input logic [7:0] p, input string tag);
    reset = 1'b1;
    price = p;
    @(posedge clk);
    #1;
    check(tag, BAND);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    price  = 8'd200;

    // Reset with an ABOVE price present: price must be ignored.
    @(posedge clk);
    #1;
    check("reset_1", BAND);
    reset_step(8'd200, "reset_2");

    // Steady in-band.
    step(8'd100, BAND, "inband_1");
    step(8'd100, BAND, "inband_2");

    // Rise to HIGH after three ABOVE, stay, then back on an in-band sample.
    step(8'd110, BAND, "up_1");
    step(8'd106, BAND, "up_2");
    step(8'd107, HIGH, "up_3_high");
    step(8'd115, HIGH, "high_hold");
    step(8'd104, BAND, "high_to_band");

    // Fall to LOW after three BELOW, stay, then back.
    step(8'd90,  BAND, "dn_1");
    step(8'd93,  BAND, "dn_2");
    step(8'd92,  LOW,  "dn_3_low");
    step(8'd94,  LOW,  "low_hold");
    step(8'd101, BAND, "low_to_band");

    // Interrupted debounce restarts the count.
    step(8'd110, BAND, "intr_1");
    step(8'd100, BAND, "intr_gap");
    step(8'd110, BAND, "intr_2");
    step(8'd110, BAND, "intr_3");
    step(8'd110, HIGH, "intr_4_high");
    step(8'd100, BAND, "intr_back");

    // Prices equal to either band are in-band.
    step(8'd105, BAND, "edge_hi_1");
    step(8'd105, BAND, "edge_hi_2");
    step(8'd105, BAND, "edge_hi_3");
    step(8'd95,  BAND, "edge_lo_1");
    step(8'd95,  BAND, "edge_lo_2");
    step(8'd95,  BAND, "edge_lo_3");
    // Just outside the bands does count.
    step(8'd106, BAND, "edge_hi_out_1");
    step(8'd106, BAND, "edge_hi_out_2");
    step(8'd106, HIGH, "edge_hi_out_3");

    // HIGH -> BELOW goes to BAND and counts as the first BELOW sample.
    step(8'd90,  BAND, "hi_below_1");
    step(8'd90,  BAND, "hi_below_2");
    step(8'd90,  LOW,  "hi_below_3_low");

    // LOW -> ABOVE goes to BAND and counts as the first ABOVE sample.
    step(8'd94,  LOW,  "low_hold_2");
    step(8'd110, BAND, "lo_above_1");
    step(8'd110, BAND, "lo_above_2");
    step(8'd110, HIGH, "lo_above_3_high");
    step(8'd100, BAND, "back_band");

    // Reset mid-debounce aborts the count.
    step(8'd110, BAND, "pre_rst_1");
    step(8'd110, BAND, "pre_rst_2");
    reset_step(8'd110, "rst_mid_debounce");
    step(8'd110, BAND, "post_rst_1");
    step(8'd110, BAND, "post_rst_2");
    step(8'd110, HIGH, "post_rst_3_high");

    // Reset in HIGH and in LOW returns to BAND.
    reset_step(8'd110, "rst_in_high");
    step(8'd90,  BAND, "rl_1");
    step(8'd90,  BAND, "rl_2");
    step(8'd90,  LOW,  "rl_3_low");
    reset_step(8'd90, "rst_in_low");
    step(8'd90,  BAND, "rl_after_1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
